// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N-channel cache line arbiter sharing one registered memory port
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ch_read/ch_write      per-channel line requests, held until ch_ready
//   ch_addr/ch_wdata      packed per-channel line address / write line
//   ch_rdata              read line returned to the granted channel
//   ch_ready              one-cycle completion pulse to the granted channel
//   mem_read/mem_write    registered memory request, held until mem_ready
//   mem_addr/mem_wdata    registered memory address / write line
//   mem_rdata/mem_ready   memory read line and completion
module mem_port_arbiter #(
   parameter int NCH        = 2,
   parameter int ADDR_W     = 28,
   parameter int LINE_W     = 128,
   parameter int FIXED_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH-1:0]        ch_read,
   input  logic [NCH-1:0]        ch_write,
   input  logic [NCH*ADDR_W-1:0] ch_addr,
   input  logic [NCH*LINE_W-1:0] ch_wdata,
   output logic [LINE_W-1:0]     ch_rdata,
   output logic [NCH-1:0]        ch_ready,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [LINE_W-1:0]     mem_wdata,
   input  logic [LINE_W-1:0]     mem_rdata,
   input  logic                  mem_ready
);
   localparam int IW = $clog2(NCH);
   localparam logic [IW:0] NCHV = (IW+1)'(NCH);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
   logic [1:0]     state;
   logic [IW-1:0]  rr_ptr, gnt, win, off;
   logic [NCH-1:0] mask, req, rot, pick;
   logic [IW:0]    sum, nxt;
   assign req = (ch_read | ch_write) & ~mask;
   // rotate so that bit 0 is the channel at rr_ptr; lowest set bit is the winner offset
   assign rot = NCH'({req, req} >> rr_ptr);
   assign pick = FIXED_PRIO != 0 ? req : rot;
   always_comb begin
      off = '0;
      for (int k = NCH-1; k >= 0; k--)
         if (pick[k]) off = IW'(k);
   end
   assign sum = {1'b0, off} + (FIXED_PRIO != 0 ? (IW+1)'(0) : {1'b0, rr_ptr});
   assign win = IW'(sum >= NCHV ? sum - NCHV : sum);
   assign nxt = {1'b0, win} + 1'b1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ch_rdata  <= '0;
         ch_ready  <= '0;
         rr_ptr    <= '0;
         gnt       <= '0;
         mask      <= '0;
      end else begin
         ch_ready <= '0;
         mask     <= '0;
         case (state)
            IDLE: if (|pick) begin
               // a write wins over a simultaneous read; the read is re-arbitrated later
               gnt       <= win;
               mem_write <= ch_write[win];
               mem_read  <= ~ch_write[win];
               mem_addr  <= ch_addr[win*ADDR_W +: ADDR_W];
               mem_wdata <= ch_wdata[win*LINE_W +: LINE_W];
               if (FIXED_PRIO == 0) rr_ptr <= nxt == NCHV ? '0 : nxt[IW-1:0];
               state     <= BUSY;
            end
            BUSY: if (mem_ready) begin
               if (mem_read) ch_rdata <= mem_rdata;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               ch_ready  <= NCH'(1) << gnt;
               state     <= RESP;
            end
            RESP: begin
               // hide the just-served channel for one IDLE cycle while it drops its request
               mask  <= NCH'(1) << gnt;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-channel line-memory arbiter that lets several caches (I-cache, D-cache, future L1 banks) share one slow off-chip memory port instead of each owning a dedicated one. Each channel speaks the existing cache-to-memory line protocol (read/write request held until ready, 128-bit lines, address bits [31:4]). The arbiter serialises requests, registers the memory-side request, and routes the response back to the requester. It sits at chip top level between the cache instances and the memory pins.

## Interface
- NCH, 2: number of requesting channels (2..8)
- ADDR_W, 28: line address width (byte address bits [31:4])
- LINE_W, 128: line data width
- FIXED_PRIO, 0: 0 = round-robin grant; 1 = fixed priority, channel 0 highest
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ch_read  input  NCH  per-channel line read request, held until ch_ready
- ch_write  input  NCH  per-channel line write request, held until ch_ready
- ch_addr  input  NCH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata  input  NCH*LINE_W  packed write lines, channel i at [i*LINE_W +: LINE_W]
- ch_rdata  output  LINE_W  read line, shared by all channels, valid when ch_ready[i]
- ch_ready  output  NCH  one-cycle completion pulse to the granted channel
- mem_read  output  1  registered memory read request
- mem_write  output  1  registered memory write request
- mem_addr  output  ADDR_W  registered memory line address
- mem_wdata  output  LINE_W  registered memory write line
- mem_rdata  input  LINE_W  memory read line, valid with mem_ready
- mem_ready  input  1  memory completion, may be a pulse or a level

## Operation
- Request on channel i = ch_read[i] | ch_write[i]. Both high on one channel: serviced as a write; the still-held read is re-arbitrated as a new transaction.
- States: IDLE, BUSY, RESP.
- IDLE: if any unmasked request, select winner g, latch op/addr/wdata of g into mem_* registers, go BUSY. No request: stay IDLE, mem_* held at last values with mem_read=mem_write=0.
- Round-robin: search starts at rr_ptr, wraps NCH-1 -> 0; after grant rr_ptr = (g+1) mod NCH. Fixed priority: lowest index wins; rr_ptr unused.
- BUSY: mem_read/mem_write held with latched addr/wdata; channel inputs ignored (changes on any ch_* do not affect the memory request). On mem_ready=1: capture mem_rdata into ch_rdata (reads only; writes leave ch_rdata unchanged), clear mem_read/mem_write, set ch_ready[g], go RESP.
- RESP: ch_ready[g]=1 for exactly this cycle; go IDLE. Channel g's request is masked during the following IDLE cycle only (covers requester drop latency); other channels arbitrate normally in that cycle.
- mem_ready while IDLE or RESP is ignored.
- At most one bit of ch_ready high in any cycle.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, ch_rdata=0, ch_ready=0, rr_ptr=0, mask cleared. Reset during BUSY aborts the transaction; no ch_ready is issued.
- Request sampled in IDLE cycle T -> mem_read/mem_write high from cycle T+1.
- mem_ready high in cycle M (BUSY) -> ch_ready[g] and ch_rdata valid in cycle M+1; mem_read/mem_write low in M+1.
- Back-to-back: IDLE at M+2, next memory request asserted at M+3 earliest. Minimum overhead 3 cycles per transaction beyond memory latency.
- mem_ready asserted in the first BUSY cycle is honoured (zero-wait memory legal).

## Test plan
- NCH=2, ch_read[0] addr 28'h0000010 alone, memory returns 128'hDEAD..BEEF after 4 cycles -> mem_addr=28'h0000010, ch_ready=2'b01 one cycle, ch_rdata matches; ch_ready[1] never high.
- ch_write[1] addr 28'h0000abc wdata 128'h0123..cdef -> mem_write=1, mem_wdata/mem_addr match, ch_rdata unchanged, ch_ready=2'b10 one cycle.
- Round-robin, ch0 and ch1 reading continuously for 6 transactions -> grant order 0,1,0,1,0,1; no channel serviced twice in a row.
- FIXED_PRIO=1, ch0 and ch1 continuously requesting -> ch0 granted every transaction except the masked cycle after its own RESP, where ch1 wins; ch1 serviced every other transaction.
- NCH=4, requests on ch3 then ch0 and ch2 simultaneously, rr_ptr=3 -> grant 3, then 0 (wrap), then 2.
- rst_n low mid-BUSY with mem_read=1 -> all outputs to reset values immediately, no ch_ready; after release a fresh request is serviced normally.
